// File: rtl/mem_access_stage_if.sv
// Byte-wide data-memory bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: byte load/store over a req/ack bus, stalls upstream while busy and
// launches a registered MEM/WB bundle. Optional ack timeout enabled by MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic        we_mem,
  input  logic        sel_dat,
  input  logic        sel_c,
  input  logic        sel_v,
  input  logic        we_c,
  input  logic [31:0] result,
  input  logic [7:0]  DoB_byte,
  input  logic [3:0]  Rg_mem,
  output logic        stall_out,
  output logic        wb_valid,
  output logic        wb_rf_we,
  output logic [31:0] wb_data,
  output logic [3:0]  wb_rg,
  output logic        wb_sel_c,
  output logic        wb_sel_v,
  output logic        wb_we_c,
`ifdef MEM_TIMEOUT_EN
  output logic        mem_err,
`endif
  mem_access_stage_if.master mem
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  // Instruction captured on ACCESS entry
  logic              ld_q, ld_d, sc_q, sc_d, sv_q, sv_d, wc_q, wc_d;
  logic [31:0]       res_q, res_d;
  logic [3:0]        rg_q, rg_d;
  // MEM/WB bundle
  logic              wbv_q, wbv_d, wbrf_q, wbrf_d;
  logic [31:0]       wbdata_q, wbdata_d;
  logic [3:0]        wbrg_q, wbrg_d;
  logic              wbsc_q, wbsc_d, wbsv_q, wbsv_d, wbwc_q, wbwc_d;
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT);
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ld_d     = ld_q;
    sc_d     = sc_q;
    sv_d     = sv_q;
    wc_d     = wc_q;
    res_d    = res_q;
    rg_d     = rg_q;
    wbv_d    = 1'b0;
    wbrf_d   = wbrf_q;
    wbdata_d = wbdata_q;
    wbrg_d   = wbrg_q;
    wbsc_d   = wbsc_q;
    wbsv_d   = wbsv_q;
    wbwc_d   = wbwc_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (valid_in && (we_mem || sel_dat)) begin
          state_d = StAccess;
          req_d   = 1'b1;
          we_d    = we_mem;
          addr_d  = result[ADDR_W-1:0];
          wdata_d = DoB_byte;
          ld_d    = ~we_mem;  // store wins when both we_mem and sel_dat are set
          sc_d    = sel_c;
          sv_d    = sel_v;
          wc_d    = we_c;
          res_d   = result;
          rg_d    = Rg_mem;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (valid_in) begin
          wbv_d    = 1'b1;
          wbrf_d   = 1'b1;
          wbdata_d = result;
          wbrg_d   = Rg_mem;
          wbsc_d   = sel_c;
          wbsv_d   = sel_v;
          wbwc_d   = we_c;
        end
      end
      StAccess: begin
        if (mem.mem_ack) begin
          state_d  = StIdle;
          req_d    = 1'b0;
          wbv_d    = 1'b1;
          wbrf_d   = ld_q;
          wbdata_d = ld_q ? {24'b0, mem.mem_rdata} : res_q;
          wbrg_d   = rg_q;
          wbsc_d   = sc_q;
          wbsv_d   = sv_q;
          wbwc_d   = wc_q;
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d  = StIdle;
          req_d    = 1'b0;
          wbv_d    = 1'b1;
          wbrf_d   = 1'b0;
          wbdata_d = res_q;
          wbrg_d   = rg_q;
          wbsc_d   = sc_q;
          wbsv_d   = sv_q;
          wbwc_d   = wc_q;
          err_d    = 1'b1;
        end else begin
          cnt_d    = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ld_q     <= 1'b0;
      sc_q     <= 1'b0;
      sv_q     <= 1'b0;
      wc_q     <= 1'b0;
      res_q    <= '0;
      rg_q     <= '0;
      wbv_q    <= 1'b0;
      wbrf_q   <= 1'b0;
      wbdata_q <= '0;
      wbrg_q   <= '0;
      wbsc_q   <= 1'b0;
      wbsv_q   <= 1'b0;
      wbwc_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ld_q     <= ld_d;
      sc_q     <= sc_d;
      sv_q     <= sv_d;
      wc_q     <= wc_d;
      res_q    <= res_d;
      rg_q     <= rg_d;
      wbv_q    <= wbv_d;
      wbrf_q   <= wbrf_d;
      wbdata_q <= wbdata_d;
      wbrg_q   <= wbrg_d;
      wbsc_q   <= wbsc_d;
      wbsv_q   <= wbsv_d;
      wbwc_q   <= wbwc_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign stall_out     = (state_q != StIdle);
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign wb_valid      = wbv_q;
  assign wb_rf_we      = wbrf_q;
  assign wb_data       = wbdata_q;
  assign wb_rg         = wbrg_q;
  assign wb_sel_c      = wbsc_q;
  assign wb_sel_v      = wbsv_q;
  assign wb_we_c       = wbwc_q;
`ifdef MEM_TIMEOUT_EN
  assign mem_err       = err_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a transaction-level reference model.
module tb_mem_access_stage;
  localparam int unsigned AW = 16;
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO     = 8;
  localparam bit          TMO    = 1'b1;
  localparam int unsigned MaxDly = 11;
`else
  localparam int unsigned TO     = 64;
  localparam bit          TMO    = 1'b0;
  localparam int unsigned MaxDly = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0, we_mem = 1'b0, sel_dat = 1'b0;
  logic        sel_c = 1'b0, sel_v = 1'b0, we_c = 1'b0;
  logic [31:0] result = '0;
  logic [7:0]  DoB_byte = '0;
  logic [3:0]  Rg_mem = '0;
  logic        stall_out, wb_valid, wb_rf_we, wb_sel_c, wb_sel_v, wb_we_c;
  logic [31:0] wb_data;
  logic [3:0]  wb_rg;
  logic        mem_err_obs;

  mem_access_stage_if #(.ADDR_W(AW)) mbus ();

  mem_access_stage #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .we_mem   (we_mem),
    .sel_dat  (sel_dat),
    .sel_c    (sel_c),
    .sel_v    (sel_v),
    .we_c     (we_c),
    .result   (result),
    .DoB_byte (DoB_byte),
    .Rg_mem   (Rg_mem),
    .stall_out(stall_out),
    .wb_valid (wb_valid),
    .wb_rf_we (wb_rf_we),
    .wb_data  (wb_data),
    .wb_rg    (wb_rg),
    .wb_sel_c (wb_sel_c),
    .wb_sel_v (wb_sel_v),
    .wb_we_c  (wb_we_c),
`ifdef MEM_TIMEOUT_EN
    .mem_err  (mem_err_obs),
`endif
    .mem      (mbus)
  );

`ifndef MEM_TIMEOUT_EN
  assign mem_err_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_tot = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding instruction at most
  bit          busy = 1'b0, no_new = 1'b0;
  int          acc_n = 0, ack_dly = 0;
  logic        p_ld, p_sc, p_sv, p_wc;
  logic [31:0] p_res;
  logic [3:0]  p_rg;
  logic        e_stall = 0, e_req = 0, e_we = 0, e_wbv = 0, e_rf = 0, e_err = 0;
  logic        e_sc = 0, e_sv = 0, e_wc = 0;
  logic [AW-1:0] e_addr = '0;
  logic [7:0]  e_wd = '0;
  logic [31:0] e_data = '0;
  logic [3:0]  e_rg = '0;

  task automatic check_all();
    check_eq("stall_out", 32'(stall_out), 32'(e_stall));
    check_eq("mem_req", 32'(mbus.mem_req), 32'(e_req));
    check_eq("mem_we", 32'(mbus.mem_we), 32'(e_we));
    check_eq("mem_addr", 32'(mbus.mem_addr), 32'(e_addr));
    check_eq("mem_wdata", 32'(mbus.mem_wdata), 32'(e_wd));
    check_eq("wb_valid", 32'(wb_valid), 32'(e_wbv));
    check_eq("wb_rf_we", 32'(wb_rf_we), 32'(e_rf));
    check_eq("wb_data", wb_data, e_data);
    check_eq("wb_rg", 32'(wb_rg), 32'(e_rg));
    check_eq("wb_flags", 32'({wb_sel_c, wb_sel_v, wb_we_c}), 32'({e_sc, e_sv, e_wc}));
    check_eq("mem_err", 32'(mem_err_obs), 32'(e_err));
  endtask

  task automatic retire(input logic [31:0] d, input logic rf, input logic err);
    busy   = 1'b0;
    e_req  = 1'b0;
    e_stall = 1'b0;
    e_wbv  = 1'b1;
    e_rf   = rf;
    e_data = d;
    e_rg   = p_rg;
    e_sc   = p_sc;
    e_sv   = p_sv;
    e_wc   = p_wc;
    e_err  = err;
  endtask

  // Drive one cycle of stimulus and advance the model to what the next edge should produce
  task automatic step();
    e_wbv = 1'b0;
    e_err = 1'b0;
    valid_in = no_new ? 1'b0 : 1'($urandom);
    we_mem   = ($urandom_range(0, 2) == 0);
    sel_dat  = ($urandom_range(0, 2) == 0);
    sel_c    = 1'($urandom);
    sel_v    = 1'($urandom);
    we_c     = 1'($urandom);
    result   = $urandom;
    DoB_byte = 8'($urandom);
    Rg_mem   = 4'($urandom);
    mbus.mem_rdata = 8'($urandom);
    mbus.mem_ack   = 1'b0;
    if (busy) begin
      if (acc_n == ack_dly) begin
        mbus.mem_ack = 1'b1;
        retire(p_ld ? {24'b0, mbus.mem_rdata} : p_res, p_ld, 1'b0);
      end else if (TMO && acc_n == int'(TO) - 1) begin
        retire(p_res, 1'b0, 1'b1);
      end else begin
        acc_n++;
      end
    end else begin
      mbus.mem_ack = ($urandom_range(0, 5) == 0);  // spurious ack while idle
      if (valid_in && (we_mem || sel_dat)) begin
        busy    = 1'b1;
        acc_n   = 0;
        ack_dly = $urandom_range(0, MaxDly);
        p_ld    = !we_mem;
        p_res   = result;
        p_rg    = Rg_mem;
        p_sc    = sel_c;
        p_sv    = sel_v;
        p_wc    = we_c;
        e_req   = 1'b1;
        e_stall = 1'b1;
        e_we    = we_mem;
        e_addr  = result[AW-1:0];
        e_wd    = DoB_byte;
      end else if (valid_in) begin
        e_wbv  = 1'b1;
        e_rf   = 1'b1;
        e_data = result;
        e_rg   = Rg_mem;
        e_sc   = sel_c;
        e_sv   = sel_v;
        e_wc   = we_c;
      end
    end
  endtask

  initial begin
    mbus.mem_ack   = 1'b0;
    mbus.mem_rdata = '0;
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      check_all();
      step();
    end
    no_new = 1'b1;
    for (int i = 0; i < 40 && busy; i++) begin
      @(negedge clk);
      check_all();
      step();
    end
    check_eq("drain_bound", 32'(busy), 32'd0);
    @(negedge clk);
    check_all();
    // Reset in the middle of an access
    valid_in = 1'b1;
    we_mem   = 1'b0;
    sel_dat  = 1'b1;
    result   = 32'h0000_00A0;
    mbus.mem_ack = 1'b0;
    @(negedge clk);
    valid_in = 1'b0;
    check_eq("rst_pre_req", 32'(mbus.mem_req), 32'd1);
    check_eq("rst_pre_addr", 32'(mbus.mem_addr), 32'h00A0);
    check_eq("rst_pre_stall", 32'(stall_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_req", 32'(mbus.mem_req), 32'd0);
    check_eq("rst_stall", 32'(stall_out), 32'd0);
    check_eq("rst_wbv", 32'(wb_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mbus.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("post_rst_wbv", 32'(wb_valid), 32'd0);
      check_eq("post_rst_req", 32'(mbus.mem_req), 32'd0);
    end
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
